// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, ALU op encodings and controller states for calc_controller
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ENTER_A,
    OP_SEEN,
    ENTER_B,
    EXEC,
    CAPTURE,
    SHOW,
    ERR
  } calc_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_op_key(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the op encoding is simply the offset from KEY_ADD.
  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    logic [3:0] off;
    off = code - KEY_ADD;
    return off[1:0];
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// rtl/calc_digit_acc.sv - acc*10+digit at 2N+4 bits; holds acc when the result exceeds N bits
module calc_digit_acc #(
  parameter int N = 32
) (
  input  logic [N-1:0] acc_i,
  input  logic [3:0]   digit_i,
  output logic [N-1:0] acc_o,
  output logic         ovf_o
);
  localparam int W = 2 * N + 4;

  logic [W-1:0] wide;

  assign wide  = ({{(N + 4){1'b0}}, acc_i} * W'(10)) + W'(digit_i);
  assign ovf_o = |wide[W-1:N];
  assign acc_o = ovf_o ? acc_i : wide[N-1:0];

endmodule

// File: rtl/n_bit_alu.sv
// rtl/n_bit_alu.sv - shared combinational ALU: low N bits of a op b, unsigned
module n_bit_alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [N-1:0] result_o
);
  import calc_pkg::*;

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_MUL:  result_o = a_i * b_i;
      default: result_o = (b_i == '0) ? '0 : a_i / b_i;
    endcase
  end

endmodule

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - keypad-driven initiator for n_bit_alu: operand entry, op select, result capture
module calc_controller
  import calc_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic         key_ready,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] display,
  output logic         error
);

  calc_state_t  state_q;
  logic [N-1:0] acc_q;
  logic [N-1:0] alu_a_q;
  logic [N-1:0] alu_b_q;
  logic [1:0]   alu_op_q;
  logic [N-1:0] display_q;
  logic         error_q;
  logic [1:0]   pend_op_q;
  logic         pend_valid_q;

  logic [N-1:0] acc_next;
  logic         acc_ovf;
  logic         accept;
  logic [N-1:0] digit_val;

  calc_digit_acc #(.N(N)) u_digit_acc (
    .acc_i   (acc_q),
    .digit_i (key_code),
    .acc_o   (acc_next),
    .ovf_o   (acc_ovf)
  );

  assign key_ready = (state_q != EXEC) && (state_q != CAPTURE);
  assign accept    = key_valid && key_ready;
  assign digit_val = {{(N - 4){1'b0}}, key_code};

  always_ff @(posedge clk) begin
    if (rst || (accept && key_code == KEY_CLR)) begin
      state_q      <= ENTER_A;
      acc_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_ADD;
      display_q    <= '0;
      error_q      <= 1'b0;
      pend_op_q    <= OP_ADD;
      pend_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (accept && is_digit(key_code)) begin
            acc_q     <= acc_ovf ? acc_q : acc_next;
            display_q <= acc_next;
          end else if (accept && state_q == ENTER_A && is_op_key(key_code)) begin
            alu_a_q  <= acc_q;
            alu_op_q <= key_to_op(key_code);
            acc_q    <= '0;
            state_q  <= OP_SEEN;
          end else if (accept && state_q == ENTER_A && key_code == KEY_EQ) begin
            display_q <= acc_q;
          end else if (accept) begin
            // ENTER_B: an op key both finishes this calculation and queues the next op.
            alu_b_q      <= acc_q;
            pend_op_q    <= key_to_op(key_code);
            pend_valid_q <= is_op_key(key_code);
            state_q      <= EXEC;
          end
        end
        OP_SEEN: begin
          if (accept && is_digit(key_code)) begin
            acc_q     <= digit_val;
            display_q <= digit_val;
            state_q   <= ENTER_B;
          end else if (accept && is_op_key(key_code)) begin
            alu_op_q <= key_to_op(key_code);
          end else if (accept) begin
            alu_b_q <= alu_a_q;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (alu_op_q == OP_DIV && alu_b_q == '0) begin
            error_q   <= 1'b1;
            display_q <= '0;
            state_q   <= ERR;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          display_q <= alu_result;
          alu_a_q   <= alu_result;
          acc_q     <= '0;
          if (pend_valid_q) begin
            alu_op_q     <= pend_op_q;
            pend_valid_q <= 1'b0;
            state_q      <= OP_SEEN;
          end else begin
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (accept && is_digit(key_code)) begin
            acc_q     <= digit_val;
            display_q <= digit_val;
            state_q   <= ENTER_A;
          end else if (accept && is_op_key(key_code)) begin
            alu_op_q <= key_to_op(key_code);
            state_q  <= OP_SEEN;
          end else if (accept) begin
            state_q <= EXEC;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= ENTER_A;
        end
      endcase
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign display = display_q;
  assign error   = error_q;

endmodule
